// File: rtl/neuron_core_pkg.sv
// Shared constants and types for the neuron core scheduler.
// Event layout, core register offsets and FSM state encoding.
package neuron_core_pkg;

    localparam int AXON_W    = 8;
    localparam int OUT_WORDS = 8;

    localparam logic [31:0] SPIKE_OFS = 32'h0000_0000;
    localparam logic [31:0] TICK_OFS  = 32'h0000_0004;
    localparam logic [31:0] OUT_OFS   = 32'h0000_0010;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WR_SPK,
        WR_TICK,
        RD_OUT
    } state_e;

    typedef struct packed {
        logic              last;
        logic [AXON_W-1:0] axon;
    } evt_t;

    function automatic logic [31:0] out_adr(
        input logic [31:0] base,
        input logic [2:0]  k
    );
        return base + OUT_OFS + {27'b0, k, 2'b00};
    endfunction

endpackage

// File: rtl/neuron_core_scheduler_if.sv
// Wishbone classic-cycle bus between the scheduler (master)
// and the neuron core slave port.
interface neuron_core_scheduler_if;

    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    modport master (
        output m_cyc_o, m_stb_o, m_we_o,
        output m_sel_o, m_adr_o, m_dat_o,
        input  m_ack_i, m_dat_i
    );

    modport slave (
        input  m_cyc_o, m_stb_o, m_we_o,
        input  m_sel_o, m_adr_o, m_dat_o,
        output m_ack_i, m_dat_i
    );

endinterface

// File: rtl/sched_event_fifo.sv
// Synchronous event FIFO; DEPTH must be a power of 2.
// Pointers carry one extra wrap bit to tell full from empty.
module sched_event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot, so a full FIFO may still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + ONE;
            if (do_pop)  rd_q <= rd_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/neuron_core_scheduler.sv
// Wishbone master that writes spike events, ticks and reads back a core.
// Optional ack watchdog: define WB_TIMEOUT_EN.
module neuron_core_scheduler
    import neuron_core_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] CORE_BASE  = 32'h3000_0000
`ifdef WB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT    = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evt_valid,
    output logic                 evt_ready,
    input  logic [AXON_W-1:0]    evt_axon,
    input  logic                 evt_last,
    neuron_core_scheduler_if.master wb,
    output logic                 out_valid,
    output logic [2:0]           out_idx,
    output logic [31:0]          out_data,
    output logic                 busy,
    output logic                 err
);

    state_e      state_q;
    logic        last_q;
    logic [2:0]  k_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        ov_q;
    logic [2:0]  oidx_q;
    logic [31:0] odata_q;

    evt_t head;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic ack;

    assign pop       = (state_q == POP);
    assign evt_ready = !full || pop;
    assign push      = evt_valid && evt_ready;
    assign ack       = wb.m_ack_i && stb_q;

    sched_event_fifo #(
        .WIDTH (AXON_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({evt_last, evt_axon}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef WB_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            k_q     <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ov_q    <= 1'b0;
            oidx_q  <= '0;
            odata_q <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ov_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!empty) state_q <= POP;
                end
                POP: begin
                    last_q  <= head.last;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    adr_q   <= CORE_BASE + SPIKE_OFS;
                    dat_q   <= {24'b0, head.axon};
                    state_q <= WR_SPK;
                end
                WR_SPK: begin
                    if (ack) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        state_q <= last_q ? WR_TICK : IDLE;
                    end
                end
                // stb low on entry gives the idle gap before the strobe.
                WR_TICK: begin
                    if (!stb_q) begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= CORE_BASE + TICK_OFS;
                        dat_q <= '0;
                    end else if (ack) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        k_q     <= '0;
                        state_q <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (!stb_q) begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= out_adr(CORE_BASE, k_q);
                        dat_q <= '0;
                    end else if (ack) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        ov_q    <= 1'b1;
                        oidx_q  <= k_q;
                        odata_q <= wb.m_dat_i;
                        k_q     <= k_q + 3'd1;
                        if (k_q == 3'(OUT_WORDS - 1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef WB_TIMEOUT_EN
            // Abort overrides whatever the state step chose.
            if (stb_q && !wb.m_ack_i) begin
                if (tmo_q == 8'(TIMEOUT - 1)) begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    err_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    tmo_q <= tmo_q + 8'd1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign wb.m_cyc_o = cyc_q;
    assign wb.m_stb_o = stb_q;
    assign wb.m_we_o  = we_q;
    assign wb.m_sel_o = 4'hF;
    assign wb.m_adr_o = adr_q;
    assign wb.m_dat_o = dat_q;

    assign out_valid = ov_q;
    assign out_idx   = oidx_q;
    assign out_data  = odata_q;
    assign busy      = (state_q != IDLE);

endmodule
